rca_slice_sequencer: RTL and testbench

Multi-cycle wide-operand adder controller that sits directly upstream and downstream of the 4-bit ripple_adder.
It accepts WIDTH-bit operands over a valid/ready handshake and drives one 4-bit slice per cycle into the external ripple_adder, least-significant slice first.
Carry between slices is registered, and the slice sums are assembled into a WIDTH-bit result presented on an output valid/ready handshake.
Lets the team build 8/16/32-bit adds from the single verified 4-bit RCA.

---
 rtl/rca_slice_sequencer.sv | 131 +++++++++++++
 tb/tb_rca_slice_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rca_slice_sequencer.sv
// Wide-operand adder controller: feeds one 4-bit slice per cycle into an external
// ripple_adder (LSB slice first) and assembles the WIDTH-bit result behind a valid/ready handshake.
module rca_slice_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NSLICES = WIDTH / 4;
  localparam int unsigned KW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam int unsigned IW      = KW + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [IW-1:0]    slice_lsb;
  logic             last_slice;

  // Bit offset of the current slice; k*4 formed by appending two zero bits.
  assign slice_lsb  = {k_q, 2'b00};
  assign last_slice = (k_q == KW'(NSLICES - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[slice_lsb +: 4] = add_sum;
        carry_d                  = add_cout;
        if (last_slice) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registers; no path from in_* to add_*.
  always_comb begin
    in_ready  = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    out_ovf   = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        add_a   = a_q[slice_lsb +: 4];
        add_b   = b_q[slice_lsb +: 4];
        add_cin = carry_q;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_sum   = result_q;
        out_cout  = carry_q;
        out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_q[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Bench for rca_slice_sequencer: a behavioural 4-bit adder stands in for ripple_adder,
// and expected slices/results come from whole-operand integer arithmetic.
module tb_rca_slice_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned NS = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the external 4-bit ripple_adder.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  rca_slice_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Carry entering slice k: carry out of the low 4k bits of a+b+cin.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int k);
    longint unsigned mask, s;
    mask = (64'd1 << (4 * k)) - 64'd1;
    s    = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
    return s[4 * k];
  endfunction

  function automatic logic [3:0] slice_of(input logic [W-1:0] v, input int k);
    longint unsigned x;
    x = 64'(v) >> (4 * k);
    return x[3:0];
  endfunction

  // Signed overflow: true two's-complement sum falls outside the W-bit range.
  function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    return (s > longint'((64'd1 << (W - 1)) - 1)) || (s < -longint'(64'd1 << (W - 1)));
  endfunction

  // One full operation with `hold` cycles of backpressure before the output handshake.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int hold);
    logic [W:0]   full;
    logic [W-1:0] exp_sum;
    logic         exp_cout, exp_ovf;
    full     = (W + 1)'(a) + (W + 1)'(b) + (W + 1)'(cin);
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = ovf_of(a, b, cin);

    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);

    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      chk($sformatf("%s.run%0d_valid", tag, k), 64'(out_valid), 64'd0);
      chk($sformatf("%s.run%0d_ready", tag, k), 64'(in_ready), 64'd0);
      chk($sformatf("%s.run%0d_a", tag, k), 64'(add_a), 64'(slice_of(a, k)));
      chk($sformatf("%s.run%0d_b", tag, k), 64'(add_b), 64'(slice_of(b, k)));
      chk($sformatf("%s.run%0d_cin", tag, k), 64'(add_cin), 64'(carry_into(a, b, cin, k)));
      in_valid = 1'($urandom);
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk($sformatf("%s.done%0d_valid", tag, h), 64'(out_valid), 64'd1);
      chk($sformatf("%s.done%0d_ready", tag, h), 64'(in_ready), 64'd0);
      chk($sformatf("%s.done%0d_sum", tag, h), 64'(out_sum), 64'(exp_sum));
      chk($sformatf("%s.done%0d_cout", tag, h), 64'(out_cout), 64'(exp_cout));
      chk($sformatf("%s.done%0d_ovf", tag, h), 64'(out_ovf), 64'(exp_ovf));
      chk($sformatf("%s.done%0d_adda", tag, h), 64'(add_a), 64'd0);
      in_valid = (h < hold) ? 1'($urandom) : 1'b0;
      in_a = W'($urandom);
      if (h == hold) out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".after_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".after_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_sum", 64'(out_sum), 64'd0);
    chk("rst.out_cout", 64'(out_cout), 64'd0);
    chk("rst.out_ovf", 64'(out_ovf), 64'd0);
    chk("rst.add", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("t1", 16'h1234, 16'h4321, 1'b0, 0);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1);
    do_op("t3b", 16'h8000, 16'h8000, 1'b0, 0);
    do_op("t4", 16'h0009, 16'h000B, 1'b1, 0);
    do_op("t5", 16'hBEEF, 16'h4111, 1'b1, 3);

    // Asynchronous reset in RUN at k=2 aborts the operation.
    @(negedge clk);
    in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("t6.pre_add_a", 64'(add_a), 64'hB);
    reset = 1'b1;
    #1;
    chk("t6.rst_valid", 64'(out_valid), 64'd0);
    chk("t6.rst_add_a", 64'(add_a), 64'd0);
    chk("t6.rst_add_b", 64'(add_b), 64'd0);
    chk("t6.rst_add_cin", 64'(add_cin), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6.post_ready", 64'(in_ready), 64'd1);
    chk("t6.post_valid", 64'(out_valid), 64'd0);
    do_op("t6b", 16'h0001, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
